apb_fsm_controller: RTL and testbench

//  Downstream stage of the AHB slave interface in the AHB-to-APB bridge. Consumes its

---
 rtl/apb_fsm_controller.sv | 105 ++++++++++
 tb/tb_apb_fsm_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/apb_fsm_controller.sv
// APB master sequencer for the AHB-to-APB bridge: one SETUP/ACCESS pair per AHB transfer.
// Optional APB_PREADY_EN adds a Pready input so peripherals can extend ACCESS.
module apb_fsm_controller #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int NSEL   = 3
) (
   input  logic              Hclk,
   input  logic              Hreset,
   input  logic              valid,
   input  logic [NSEL-1:0]   tempselx,
   input  logic [ADDR_W-1:0] Haddr2,
   input  logic              Hwritereg1,
   input  logic [DATA_W-1:0] Hwdata1,
`ifdef APB_PREADY_EN
   input  logic              Pready,
`endif
   output logic              Hreadyout,
   output logic [NSEL-1:0]   Pselx,
   output logic              Penable,
   output logic              Pwrite,
   output logic [ADDR_W-1:0] Paddr,
   output logic [DATA_W-1:0] Pwdata
);

   // state  | meaning
   // IDLE   | no transfer, AHB ready
   // ADDR   | AHB data phase started, wait for delayed address/data
   // DATA   | capture address/direction/data, drive Pselx
   // SETUP  | APB setup cycle, raise Penable
   // ACCESS | APB access, completes when Pready_eff
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ADDR   = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_SETUP  = 3'd3;
   localparam logic [2:0] ST_ACCESS = 3'd4;

   logic [2:0]      state;
   logic [NSEL-1:0] sel_q;
   logic            pready_eff;

   // A decode miss must never hang the master, so it completes unconditionally.
`ifdef APB_PREADY_EN
   assign pready_eff = (sel_q == '0) | Pready;
`else
   assign pready_eff = 1'b1;
`endif

   always_comb begin
      Hreadyout = 1'b0;
      case (state)
         ST_IDLE:   Hreadyout = 1'b1;
         ST_ACCESS: Hreadyout = pready_eff;
         default:   Hreadyout = 1'b0;
      endcase
   end

   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         state   <= ST_IDLE;
         sel_q   <= '0;
         Pselx   <= '0;
         Penable <= 1'b0;
         Pwrite  <= 1'b0;
         Paddr   <= '0;
         Pwdata  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (valid) begin
                  sel_q <= tempselx;
                  state <= ST_ADDR;
               end
            end
            ST_ADDR: state <= ST_DATA;
            ST_DATA: begin
               Paddr   <= Haddr2;
               Pwrite  <= Hwritereg1;
               Pwdata  <= Hwdata1;
               Pselx   <= sel_q;
               Penable <= 1'b0;
               state   <= ST_SETUP;
            end
            ST_SETUP: begin
               Penable <= 1'b1;
               state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (pready_eff) begin
                  Pselx   <= '0;
                  Penable <= 1'b0;
                  if (valid) begin
                     sel_q <= tempselx;
                     state <= ST_ADDR;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller; covers the Pready wait-state case when APB_PREADY_EN is defined.
module tb_apb_fsm_controller;

   logic        Hclk = 1'b0;
   logic        Hreset;
   logic        valid;
   logic [2:0]  tempselx;
   logic [31:0] Haddr2;
   logic        Hwritereg1;
   logic [31:0] Hwdata1;
   logic        Pready;
   logic        Hreadyout;
   logic [2:0]  Pselx;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;

   int n_vec = 0;
   int n_err = 0;

   apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .NSEL(3)) dut (
      .Hclk       (Hclk),
      .Hreset     (Hreset),
      .valid      (valid),
      .tempselx   (tempselx),
      .Haddr2     (Haddr2),
      .Hwritereg1 (Hwritereg1),
      .Hwdata1    (Hwdata1),
`ifdef APB_PREADY_EN
      .Pready     (Pready),
`endif
      .Hreadyout  (Hreadyout),
      .Pselx      (Pselx),
      .Penable    (Penable),
      .Pwrite     (Pwrite),
      .Paddr      (Paddr),
      .Pwdata     (Pwdata)
   );

   always #5 Hclk = ~Hclk;

   task automatic tick();
      @(posedge Hclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [2:0] sel, input logic [31:0] addr,
                        input logic wr, input logic [31:0] wdata);
      valid      = 1'b1;
      tempselx   = sel;
      Haddr2     = addr;
      Hwritereg1 = wr;
      Hwdata1    = wdata;
   endtask

   initial begin
      Hreset = 1'b1; valid = 1'b0; tempselx = '0; Haddr2 = '0;
      Hwritereg1 = 1'b0; Hwdata1 = '0; Pready = 1'b1;
      tick(); tick();
      chk("rst_hready", {31'd0, Hreadyout}, 32'd1);
      chk("rst_psel",   {29'd0, Pselx},     32'd0);
      chk("rst_pen",    {31'd0, Penable},   32'd0);
      chk("rst_paddr",  Paddr,              32'd0);
      Hreset = 1'b0;
      tick();
      chk("idle_hready", {31'd0, Hreadyout}, 32'd1);

      // single write
      start(3'b001, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF);
      tick(); valid = 1'b0;
      chk("wr_t1_hready", {31'd0, Hreadyout}, 32'd0);
      tick();
      chk("wr_t2_psel",   {29'd0, Pselx},     32'd0);
      chk("wr_t2_hready", {31'd0, Hreadyout}, 32'd0);
      tick();
      chk("wr_t3_psel",   {29'd0, Pselx},     32'b001);
      chk("wr_t3_pen",    {31'd0, Penable},   32'd0);
      chk("wr_t3_paddr",  Paddr,              32'h8000_0010);
      chk("wr_t3_pwrite", {31'd0, Pwrite},    32'd1);
      chk("wr_t3_pwdata", Pwdata,             32'hDEAD_BEEF);
      chk("wr_t3_hready", {31'd0, Hreadyout}, 32'd0);
      tick();
      chk("wr_t4_pen",    {31'd0, Penable},   32'd1);
      chk("wr_t4_hready", {31'd0, Hreadyout}, 32'd1);
      tick();
      chk("wr_t5_psel",   {29'd0, Pselx},     32'd0);
      chk("wr_t5_pen",    {31'd0, Penable},   32'd0);
      chk("wr_t5_paddr_hold", Paddr,          32'h8000_0010);

      // single read
      start(3'b010, 32'h8400_0004, 1'b0, 32'h0);
      tick(); valid = 1'b0;
      tick(); tick();
      chk("rd_t3_psel",   {29'd0, Pselx},     32'b010);
      chk("rd_t3_pwrite", {31'd0, Pwrite},    32'd0);
      chk("rd_t3_paddr",  Paddr,              32'h8400_0004);
      tick();
      chk("rd_t4_pen",    {31'd0, Penable},   32'd1);
      chk("rd_t4_hready", {31'd0, Hreadyout}, 32'd1);
      tick();

      // back-to-back: write then a read presented in the completing ACCESS cycle
      start(3'b100, 32'h8800_0000, 1'b1, 32'hA5A5_5A5A);
      tick(); valid = 1'b0;
      tick(); tick();
      chk("b2b_wr_psel", {29'd0, Pselx}, 32'b100);
      tick();
      chk("b2b_wr_hready", {31'd0, Hreadyout}, 32'd1);
      start(3'b100, 32'h8800_0004, 1'b0, 32'h0);
      tick(); valid = 1'b0;
      chk("b2b_addr_psel",   {29'd0, Pselx},     32'd0);
      chk("b2b_addr_hready", {31'd0, Hreadyout}, 32'd0);
      tick();
      chk("b2b_data_psel",   {29'd0, Pselx},     32'd0);
      tick();
      chk("b2b_rd_psel",   {29'd0, Pselx},  32'b100);
      chk("b2b_rd_pwrite", {31'd0, Pwrite}, 32'd0);
      chk("b2b_rd_paddr",  Paddr,           32'h8800_0004);
      tick();
      chk("b2b_rd_pen", {31'd0, Penable}, 32'd1);
      tick();

`ifdef APB_PREADY_EN
      // three wait states in ACCESS
      start(3'b001, 32'h8000_0020, 1'b1, 32'h1234_5678);
      tick(); valid = 1'b0;
      Pready = 1'b0;
      tick(); tick(); tick();
      for (int i = 0; i < 3; i++) begin
         chk("ws_hready", {31'd0, Hreadyout}, 32'd0);
         chk("ws_pen",    {31'd0, Penable},   32'd1);
         chk("ws_psel",   {29'd0, Pselx},     32'b001);
         chk("ws_paddr",  Paddr,              32'h8000_0020);
         if (i < 2) tick();
         else begin Pready = 1'b1; #1; end
      end
      chk("ws_done_hready", {31'd0, Hreadyout}, 32'd1);
      tick();
      chk("ws_idle_pen", {31'd0, Penable}, 32'd0);
`endif

      // decode miss, Pready held low
      Pready = 1'b0;
      start(3'b000, 32'h9000_0000, 1'b0, 32'h0);
      tick(); valid = 1'b0;
      tick(); tick();
      chk("miss_t3_psel",  {29'd0, Pselx}, 32'd0);
      chk("miss_t3_paddr", Paddr,          32'h9000_0000);
      tick();
      chk("miss_t4_psel",   {29'd0, Pselx},     32'd0);
      chk("miss_t4_hready", {31'd0, Hreadyout}, 32'd1);
      tick();
      chk("miss_idle_hready", {31'd0, Hreadyout}, 32'd1);
      Pready = 1'b1;

      // reset in ACCESS aborts the transfer
      start(3'b010, 32'h8400_0008, 1'b1, 32'hCAFE_F00D);
      tick(); valid = 1'b0;
      tick(); tick(); tick();
      Pready = 1'b0;
      chk("rst_acc_pen", {31'd0, Penable}, 32'd1);
      Hreset = 1'b1;
      tick();
      chk("rst_acc_psel",   {29'd0, Pselx},     32'd0);
      chk("rst_acc_pen0",   {31'd0, Penable},   32'd0);
      chk("rst_acc_hready", {31'd0, Hreadyout}, 32'd1);
      chk("rst_acc_paddr",  Paddr,              32'd0);
      tick();
      Hreset = 1'b0; Pready = 1'b1;
      tick();
      chk("rst_acc_idle_hready", {31'd0, Hreadyout}, 32'd1);
      chk("rst_acc_idle_psel",   {29'd0, Pselx},     32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
